sram_port_arb: RTL and testbench

Single-port SRAM arbiter for the async-FIFO storage path. It shares one single-port `sram_model` instance between a write requester (FIFO push side) and a read requester (FIFO pop/prefetch side), and drives the active-low SRAM controls (NCE/NWRT) plus the address and data muxes. A bounded-burst round-robin policy stops either side from starving the other. It sits between `async_fifo`'s `sram_if` and the SRAM macro, and replaces ad-hoc combinational rd/wr muxing.

---
 rtl/sram_port_arb.sv | 65 ++++++
 tb/tb_sram_port_arb.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sram_port_arb.sv
// sram_port_arb: bounded-burst round-robin arbiter sharing one single-port SRAM
// between a write requester and a read requester.
module sram_port_arb #(
  parameter int MEM_ADDR_W = 10,
  parameter int MEM_DATA_W = 64,
  parameter int MAX_BURST  = 4
) (
  input  logic                  axi_clk,
  input  logic                  axi_resetn,
  input  logic                  ENABLE,
  input  logic                  wr_req,
  input  logic [MEM_ADDR_W-1:0] wr_addr,
  input  logic [MEM_DATA_W-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [MEM_ADDR_W-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic [MEM_DATA_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  sram_nce,
  output logic                  sram_nwrt,
  output logic [MEM_ADDR_W-1:0] sram_addr,
  output logic [MEM_DATA_W-1:0] sram_din,
  input  logic [MEM_DATA_W-1:0] sram_dout
);
  typedef enum logic {OWN_WR, OWN_RD} owner_t;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW:0] MAXB = (CW + 1)'(MAX_BURST);
  localparam logic [CW:0] ONE = (CW + 1)'(1);
  owner_t owner, owner_nx, side;
  logic [CW-1:0] burst_cnt, cnt_nx;
  logic [CW:0] cnt_inc;
  logic go, other_req, hand_off;
  always_comb begin
    go = ENABLE & axi_resetn;
    wr_gnt = go & wr_req & (~rd_req | owner == OWN_WR);
    rd_gnt = go & rd_req & (~wr_req | owner == OWN_RD);
    side = wr_gnt ? OWN_WR : OWN_RD;
    other_req = wr_gnt ? rd_req : wr_req;
    cnt_inc = side != owner ? ONE : {1'b0, burst_cnt} + ONE;
    hand_off = cnt_inc >= MAXB && other_req;
    owner_nx = owner;
    cnt_nx = burst_cnt;
    if (wr_gnt | rd_gnt) begin
      owner_nx = hand_off ? (side == OWN_WR ? OWN_RD : OWN_WR) : side;
      cnt_nx = hand_off ? '0 : (cnt_inc > MAXB ? MAXB[CW-1:0] : cnt_inc[CW-1:0]);
    end
  end
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      owner <= OWN_WR;
      burst_cnt <= '0;
      rd_valid <= 1'b0;
    end else begin
      owner <= owner_nx;
      burst_cnt <= cnt_nx;
      rd_valid <= rd_gnt;
    end
  end
  assign sram_nce = ~(wr_gnt | rd_gnt);
  assign sram_nwrt = ~wr_gnt;
  assign sram_addr = wr_gnt ? wr_addr : rd_addr;
  assign sram_din = wr_data;
  assign rd_data = sram_dout;
endmodule

// File: tb/tb_sram_port_arb.sv
// tb_sram_port_arb: table-driven grant checks with a read-data scoreboard.
module tb_sram_port_arb;
  logic axi_clk = 0, axi_resetn = 0, ENABLE = 0;
  logic wr_req = 0, rd_req = 0;
  logic [9:0] wr_addr = 0, rd_addr = 0, sram_addr;
  logic [63:0] wr_data = 0, rd_data, sram_din, sram_dout;
  logic wr_gnt, rd_gnt, rd_valid, sram_nce, sram_nwrt;
  logic [63:0] mem [1024];
  logic [63:0] shadow [1024];
  logic [63:0] q [$];
  logic exp_rv = 0;
  int n_vec = 0, n_err = 0;
  typedef struct {logic en, wq, rq, ew, er;} vec_t;
  vec_t tbl [$];

  sram_port_arb dut (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn), .ENABLE(ENABLE),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .sram_nce(sram_nce), .sram_nwrt(sram_nwrt), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 axi_clk = ~axi_clk;

  // registered-output single-port SRAM
  always @(posedge axi_clk)
    if (!sram_nce) begin
      if (!sram_nwrt) mem[sram_addr] <= sram_din;
      else sram_dout <= mem[sram_addr];
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic en, wq, rq, input logic [9:0] wa, input logic [63:0] wd,
                      input logic [9:0] ra, input logic ew, er);
    logic [63:0] e;
    chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
    if (exp_rv) begin
      if (q.size() == 0) chk("sb_empty", 64'(1), 64'(0));
      else begin
        e = q.pop_front();
        chk("rd_data", rd_data, e);
      end
    end
    ENABLE = en; wr_req = wq; rd_req = rq; wr_addr = wa; wr_data = wd; rd_addr = ra;
    #1;
    chk("wr_gnt", 64'(wr_gnt), 64'(ew));
    chk("rd_gnt", 64'(rd_gnt), 64'(er));
    chk("sram_nce", 64'(sram_nce), 64'(!(ew || er)));
    chk("sram_nwrt", 64'(sram_nwrt), 64'(!ew));
    if (ew) chk("sram_addr_w", 64'(sram_addr), 64'(wa));
    else if (er) chk("sram_addr_r", 64'(sram_addr), 64'(ra));
    if (ew) shadow[wa] = wd;
    if (er) q.push_back(shadow[ra]);
    exp_rv = er;
    @(posedge axi_clk); #1;
  endtask

  initial begin
    // reset: requests active but nothing may be granted
    ENABLE = 1; wr_req = 1; rd_req = 1;
    #12;
    chk("rst_wr_gnt", 64'(wr_gnt), 64'(0));
    chk("rst_rd_gnt", 64'(rd_gnt), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_nce", 64'(sram_nce), 64'(1));
    chk("rst_nwrt", 64'(sram_nwrt), 64'(1));
    wr_req = 0; rd_req = 0;
    @(negedge axi_clk) axi_resetn = 1;
    @(posedge axi_clk); #1;

    tbl.push_back('{1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 0});
    for (int i = 0; i < 16; i++) tbl.push_back('{1, 1, 1, (i % 8) < 4, (i % 8) >= 4});
    for (int i = 0; i < 3; i++) tbl.push_back('{1, 0, 1, 0, 1});
    tbl.push_back('{1, 1, 0, 1, 0});
    for (int i = 0; i < 3; i++) tbl.push_back('{1, 1, 1, 1, 0});
    tbl.push_back('{1, 1, 1, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 0});
    foreach (tbl[i])
      step(tbl[i].en, tbl[i].wq, tbl[i].rq, 10'h010, {32'hA5A5A5A5, 32'(i)}, 10'h010,
           tbl[i].ew, tbl[i].er);

    // write then read same address
    step(1, 1, 0, 10'h005, 64'hDEADBEEF_00000001, 10'h000, 1, 0);
    step(1, 0, 1, 10'h000, 64'h0, 10'h005, 0, 1);
    chk("wr_rd_data", rd_data, 64'hDEADBEEF_00000001);
    step(1, 0, 0, 10'h000, 64'h0, 10'h000, 0, 0);

    // read immediately followed by write to same address: read sees old value
    step(1, 0, 1, 10'h000, 64'h0, 10'h005, 0, 1);
    step(1, 1, 0, 10'h005, 64'h1234_5678_9ABC_DEF0, 10'h000, 1, 0);
    step(1, 0, 1, 10'h000, 64'h0, 10'h005, 0, 1);
    step(1, 0, 0, 10'h000, 64'h0, 10'h000, 0, 0);

    // ENABLE drop while a read is in flight
    step(1, 0, 1, 10'h000, 64'h0, 10'h005, 0, 1);
    step(0, 1, 1, 10'h005, 64'h0, 10'h005, 0, 0);
    step(0, 1, 1, 10'h005, 64'h0, 10'h005, 0, 0);

    // asynchronous reset one cycle after a read grant (owner is RD)
    step(1, 0, 1, 10'h000, 64'h0, 10'h005, 0, 1);
    chk("pre_rst_rd_valid", 64'(rd_valid), 64'(1));
    wr_req = 0; rd_req = 0;
    #2 axi_resetn = 0;
    #1;
    chk("async_rd_valid", 64'(rd_valid), 64'(0));
    chk("async_nce", 64'(sram_nce), 64'(1));
    q.delete();
    exp_rv = 0;
    @(negedge axi_clk) axi_resetn = 1;
    @(posedge axi_clk); #1;
    step(1, 1, 1, 10'h007, 64'h77, 10'h005, 1, 0);
    step(1, 1, 1, 10'h007, 64'h78, 10'h005, 1, 0);
    step(1, 0, 0, 10'h000, 64'h0, 10'h000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
